btb_update_queue: RTL

BTB_UPDATE_QUEUE -- requirements
Module: btb_update_queue

---
 rtl/btb_update_queue_if.sv | 40 ++++
 rtl/btb_update_queue.sv | 101 ++++++++++
 2 files changed

// File: rtl/btb_update_queue_if.sv
// Bundle of the resolved-branch update handshake and the BTB update0/update1 stage outputs.
// The master side offers updates and controls stall/flush; the slave side is the queue.
interface btb_update_queue_if #(
  parameter int DEPTH               = 4,
  parameter int ASID_WIDTH          = 9,
  parameter int BTB_PRED_INFO_WIDTH = 8
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic                           enq_valid;
  logic                           enq_ready;
  logic [31:0]                    enq_start_full_PC;
  logic [ASID_WIDTH-1:0]          enq_ASID;
  logic [BTB_PRED_INFO_WIDTH-1:0] enq_pred_info;
  logic                           enq_pred_lru;
  logic [31:0]                    enq_target_full_PC;
  logic                           stall;
  logic                           flush;
  logic                           update0_valid;
  logic [31:0]                    update0_start_full_PC;
  logic [ASID_WIDTH-1:0]          update0_ASID;
  logic [BTB_PRED_INFO_WIDTH-1:0] update1_pred_info;
  logic                           update1_pred_lru;
  logic [31:0]                    update1_target_full_PC;
  logic [CNT_W-1:0]               occupancy;

  modport master (
    output enq_valid, enq_start_full_PC, enq_ASID, enq_pred_info, enq_pred_lru,
           enq_target_full_PC, stall, flush,
    input  enq_ready, update0_valid, update0_start_full_PC, update0_ASID,
           update1_pred_info, update1_pred_lru, update1_target_full_PC, occupancy
  );

  modport slave (
    input  enq_valid, enq_start_full_PC, enq_ASID, enq_pred_info, enq_pred_lru,
           enq_target_full_PC, stall, flush,
    output enq_ready, update0_valid, update0_start_full_PC, update0_ASID,
           update1_pred_info, update1_pred_lru, update1_target_full_PC, occupancy
  );
endinterface

// File: rtl/btb_update_queue.sv
// Circular FIFO of resolved-branch BTB updates feeding the two-stage BTB write path.
// Optional macro BTB_UPDATE_QUEUE_COALESCE_EN merges an update into the newest entry on a PC/ASID match.
module btb_update_queue #(
  parameter int DEPTH               = 4,
  parameter int ASID_WIDTH          = 9,
  parameter int BTB_PRED_INFO_WIDTH = 8
) (
  input  logic              CLK,
  input  logic              nRST,
  btb_update_queue_if.slave q
);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [31:0]                    pc_mem   [DEPTH];
  logic [ASID_WIDTH-1:0]          asid_mem [DEPTH];
  logic [BTB_PRED_INFO_WIDTH-1:0] info_mem [DEPTH];
  logic                           lru_mem  [DEPTH];
  logic [31:0]                    tgt_mem  [DEPTH];

  logic [PW-1:0] head, tail;
  logic [PW:0]   count;
  logic          enq_fire, deq, coalesce, alloc;

  logic [BTB_PRED_INFO_WIDTH-1:0] upd1_info_p1;
  logic                           upd1_lru_p1;
  logic [31:0]                    upd1_tgt_p1;

  assign q.enq_ready             = (count != FULL_CNT);
  assign deq                     = (count != '0) && !q.stall;
  assign q.update0_valid         = deq;
  assign q.update0_start_full_PC = pc_mem[head];
  assign q.update0_ASID          = asid_mem[head];
  assign q.occupancy             = count;
  assign enq_fire                = q.enq_valid && q.enq_ready;

`ifdef BTB_UPDATE_QUEUE_COALESCE_EN
  logic [PW-1:0] tail_m1;
  logic          newest_hit;
  assign tail_m1    = tail - PW'(1);
  assign newest_hit = (pc_mem[tail_m1][31:1] == q.enq_start_full_PC[31:1]) &&
                      (asid_mem[tail_m1] == q.enq_ASID);
  // With a single entry being dequeued this cycle there is no newest entry left to merge into.
  assign coalesce   = enq_fire && newest_hit &&
                      ((count >= (PW+1)'(2)) || ((count == (PW+1)'(1)) && !deq));
`else
  assign coalesce   = 1'b0;
`endif

  assign alloc = enq_fire && !coalesce;

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else if (q.flush) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      head  <= head + PW'(deq);
      tail  <= tail + PW'(alloc);
      count <= count + (PW+1)'(alloc) - (PW+1)'(deq);
    end
  end

  always_ff @(posedge CLK) begin
    if (alloc && !q.flush) begin
      pc_mem[tail]   <= q.enq_start_full_PC;
      asid_mem[tail] <= q.enq_ASID;
      info_mem[tail] <= q.enq_pred_info;
      lru_mem[tail]  <= q.enq_pred_lru;
      tgt_mem[tail]  <= q.enq_target_full_PC;
    end
`ifdef BTB_UPDATE_QUEUE_COALESCE_EN
    if (coalesce && !q.flush) begin
      info_mem[tail_m1] <= q.enq_pred_info;
      lru_mem[tail_m1]  <= q.enq_pred_lru;
      tgt_mem[tail_m1]  <= q.enq_target_full_PC;
    end
`endif
  end

  // update0 -> update1 stage boundary: payload follows the head by one cycle, flush does not cancel it.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      upd1_info_p1 <= '0;
      upd1_lru_p1  <= 1'b0;
      upd1_tgt_p1  <= '0;
    end else if (deq) begin
      upd1_info_p1 <= info_mem[head];
      upd1_lru_p1  <= lru_mem[head];
      upd1_tgt_p1  <= tgt_mem[head];
    end
  end

  assign q.update1_pred_info      = upd1_info_p1;
  assign q.update1_pred_lru       = upd1_lru_p1;
  assign q.update1_target_full_PC = upd1_tgt_p1;
endmodule
